// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix ALU front-end sequencer.
package matrix_pkg;

    localparam int N_ELEM = 25;
    localparam int ELEM_W = 8;
    localparam int FLAT_W = N_ELEM * ELEM_W;
    localparam int IDX_W  = $clog2(N_ELEM);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    typedef enum logic [1:0] {
        CMD_LOAD_A = 2'b00,
        CMD_LOAD_B = 2'b01,
        CMD_EXEC   = 2'b10,
        CMD_CLEAR  = 2'b11
    } cmd_e;

    localparam logic [2:0] OP_IDLE     = 3'b000;
    localparam logic [2:0] OP_SUM      = 3'b001;
    localparam logic [2:0] OP_SUB      = 3'b010;
    localparam logic [2:0] OP_MUL      = 3'b011;
    localparam logic [2:0] OP_SCALE    = 3'b100;
    localparam logic [2:0] OP_TRANS    = 3'b101;
    localparam logic [2:0] OP_HADAMARD = 3'b110;
    localparam logic [2:0] OP_DET      = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_STREAM  = 3'd4
    } state_e;

endpackage

// File: rtl/matrix_result_streamer.sv
// Holds the captured ALU result and streams it out one element per valid/ready transfer.
module matrix_result_streamer
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic [FLAT_W-1:0] c_flat,
    input  logic              ovf_in,
    input  logic              res_ready,
    output logic              res_valid,
    output logic [ELEM_W-1:0] res_data,
    output logic              res_last,
    output logic              res_ovf,
    output logic              done
);

    logic [N_ELEM-1:0][ELEM_W-1:0] res_buf;
    logic [IDX_W-1:0]              rd_idx;
    logic                          valid_r;
    logic                          ovf_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_buf <= '0;
            rd_idx  <= '0;
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (capture) begin
            res_buf <= c_flat;
            ovf_r   <= ovf_in;
            rd_idx  <= '0;
            valid_r <= 1'b1;
        end else if (valid_r && res_ready) begin
            if (rd_idx == LAST_IDX) begin
                rd_idx  <= '0;
                valid_r <= 1'b0;
            end else begin
                rd_idx <= rd_idx + IDX_W'(1);
            end
        end
    end

    assign res_valid = valid_r;
    assign res_data  = res_buf[rd_idx];
    assign res_last  = valid_r && (rd_idx == LAST_IDX);
    assign res_ovf   = ovf_r;
    // Single-cycle strobe on the final handshake; the top uses it to leave STREAM.
    assign done      = valid_r && res_ready && (rd_idx == LAST_IDX);

endmodule

// File: rtl/matrix_op_sequencer.sv
// Command front-end for the matrix ALU: loads operands, sequences an opcode edge,
// captures the result and hands it to the streamer.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | accepting LOAD_A / LOAD_B / EXEC / CLEAR commands
//   ST_ARM     | opcode forced to 000 so the ALU always sees an edge
//   ST_ISSUE   | opcode = op_r for SETTLE cycles (down-counter to zero)
//   ST_CAPTURE | result and overflow registered, opcode back to 000
//   ST_STREAM  | result elements offered on res_*; last handshake -> IDLE
module matrix_op_sequencer
    import matrix_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_cmd,
    input  logic [ELEM_W-1:0] in_data,
    input  logic [2:0]        in_opcode,
    output logic [FLAT_W-1:0] A_flat,
    output logic [FLAT_W-1:0] B_flat,
    output logic [ELEM_W-1:0] f,
    output logic [2:0]        opcode,
    input  logic [FLAT_W-1:0] C_flat,
    input  logic              overflow_flag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ELEM_W-1:0] res_data,
    output logic              res_last,
    output logic              res_ovf,
    output logic              a_loaded,
    output logic              b_loaded,
    output logic              busy,
    output logic              err
);

    state_e state, state_nxt;

    logic [N_ELEM-1:0][ELEM_W-1:0] a_mat, b_mat;
    logic [IDX_W-1:0]              ptr_a, ptr_b;
    logic                          a_loaded_r, b_loaded_r;
    logic [ELEM_W-1:0]             f_r;
    logic [2:0]                    op_r;
    logic [3:0]                    settle_cnt;
    logic                          err_r;
    logic                          capture;
    logic                          stream_done;
    logic                          accept;
    logic                          exec_go;
    logic                          exec_rej;
    cmd_e                          cmd;

    assign cmd      = cmd_e'(in_cmd);
    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign exec_go  = accept && (cmd == CMD_EXEC) && (in_opcode != OP_IDLE);
    assign exec_rej = accept && (cmd == CMD_EXEC) && (in_opcode == OP_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        opcode    = OP_IDLE;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (exec_go) state_nxt = ST_ARM;
            end
            ST_ARM: begin
                state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                opcode = op_r;
                if (settle_cnt == 4'd0) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture   = 1'b1;
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (stream_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Loaded in ARM so ISSUE lasts exactly SETTLE cycles, ending on terminal count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state == ST_ARM) begin
            settle_cnt <= 4'(SETTLE - 1);
        end else if ((state == ST_ISSUE) && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mat      <= '0;
            b_mat      <= '0;
            ptr_a      <= '0;
            ptr_b      <= '0;
            a_loaded_r <= 1'b0;
            b_loaded_r <= 1'b0;
            f_r        <= '0;
            op_r       <= OP_IDLE;
            err_r      <= 1'b0;
        end else begin
            err_r <= exec_rej;
            if (accept) begin
                case (cmd)
                    CMD_LOAD_A: begin
                        a_mat[ptr_a] <= in_data;
                        if (ptr_a == LAST_IDX) begin
                            ptr_a      <= '0;
                            a_loaded_r <= 1'b1;
                        end else begin
                            ptr_a <= ptr_a + IDX_W'(1);
                        end
                    end
                    CMD_LOAD_B: begin
                        b_mat[ptr_b] <= in_data;
                        if (ptr_b == LAST_IDX) begin
                            ptr_b      <= '0;
                            b_loaded_r <= 1'b1;
                        end else begin
                            ptr_b <= ptr_b + IDX_W'(1);
                        end
                    end
                    CMD_EXEC: begin
                        if (in_opcode != OP_IDLE) begin
                            f_r  <= in_data;
                            op_r <= in_opcode;
                        end
                    end
                    CMD_CLEAR: begin
                        a_mat      <= '0;
                        b_mat      <= '0;
                        ptr_a      <= '0;
                        ptr_b      <= '0;
                        a_loaded_r <= 1'b0;
                        b_loaded_r <= 1'b0;
                        f_r        <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign A_flat   = a_mat;
    assign B_flat   = b_mat;
    assign f        = f_r;
    assign a_loaded = a_loaded_r;
    assign b_loaded = b_loaded_r;
    assign err      = err_r;

    matrix_result_streamer u_streamer (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (capture),
        .c_flat    (C_flat),
        .ovf_in    (overflow_flag),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_last  (res_last),
        .res_ovf   (res_ovf),
        .done      (stream_done)
    );

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer with a small behavioural ALU stand-in.
module tb_matrix_op_sequencer;
    import matrix_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_cmd;
    logic [7:0]   in_data;
    logic [2:0]   in_opcode;
    logic [199:0] A_flat;
    logic [199:0] B_flat;
    logic [7:0]   f;
    logic [2:0]   opcode;
    logic [199:0] c_flat;
    logic         alu_ovf;
    logic         res_valid;
    logic         res_ready;
    logic [7:0]   res_data;
    logic         res_last;
    logic         res_ovf;
    logic         a_loaded;
    logic         b_loaded;
    logic         busy;
    logic         err;

    int n_checks;
    int n_fail;
    logic [7:0]   exp_q [25];
    logic [199:0] exp_flat;

    matrix_op_sequencer #(.SETTLE(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_cmd        (in_cmd),
        .in_data       (in_data),
        .in_opcode     (in_opcode),
        .A_flat        (A_flat),
        .B_flat        (B_flat),
        .f             (f),
        .opcode        (opcode),
        .C_flat        (c_flat),
        .overflow_flag (alu_ovf),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_last      (res_last),
        .res_ovf       (res_ovf),
        .a_loaded      (a_loaded),
        .b_loaded      (b_loaded),
        .busy          (busy),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: re-evaluates on a change to a non-idle opcode and holds its result.
    logic [7:0] alu_a, alu_b, alu_s;
    always @(opcode) begin
        if (opcode != 3'b000) begin
            c_flat  = '0;
            alu_ovf = 1'b0;
            for (int k = 0; k < 25; k++) begin
                alu_a = A_flat[k*8 +: 8];
                alu_b = B_flat[k*8 +: 8];
                case (opcode)
                    3'b001: begin
                        alu_s = alu_a + alu_b;
                        c_flat[k*8 +: 8] = alu_s;
                        if ((alu_a[7] == alu_b[7]) && (alu_s[7] != alu_a[7])) alu_ovf = 1'b1;
                    end
                    3'b101: c_flat[k*8 +: 8] = A_flat[((k % 5) * 5 + k / 5) * 8 +: 8];
                    default: ;
                endcase
            end
        end
    end

    task automatic check_val(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] cmd, input logic [7:0] data, input logic [2:0] op);
        in_valid  = 1'b1;
        in_cmd    = cmd;
        in_data   = data;
        in_opcode = op;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic exec_op(input logic [2:0] op, input logic [7:0] scal);
        send(CMD_EXEC, scal, op);
        check_val("arm_opcode", 200'(opcode), 200'(3'b000));
        check_val("arm_busy", 200'(busy), 200'(1'b1));
        check_val("arm_in_ready", 200'(in_ready), 200'(1'b0));
        check_val("f_latched", 200'(f), 200'(scal));
        tick();
        check_val("issue1_opcode", 200'(opcode), 200'(op));
        tick();
        check_val("issue2_opcode", 200'(opcode), 200'(op));
        tick();
        check_val("capture_opcode", 200'(opcode), 200'(3'b000));
        check_val("capture_res_valid", 200'(res_valid), 200'(1'b0));
        tick();
        check_val("latency_res_valid", 200'(res_valid), 200'(1'b1));
    endtask

    // Consumes the stream against exp_q; stall=1 drives res_ready as 1,0,0,1 repeating.
    task automatic run_stream(input bit stall, input int stop_at, input logic exp_ovf);
        int idx = 0;
        int cyc = 0;
        while ((idx < stop_at) && (cyc < 200)) begin
            res_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            check_val($sformatf("stream_valid[%0d]", idx), 200'(res_valid), 200'(1'b1));
            check_val($sformatf("stream_data[%0d]", idx), 200'(res_data), 200'(exp_q[idx]));
            check_val($sformatf("stream_last[%0d]", idx), 200'(res_last), 200'(idx == 24));
            check_val($sformatf("stream_ovf[%0d]", idx), 200'(res_ovf), 200'(exp_ovf));
            check_val($sformatf("stream_in_ready[%0d]", idx), 200'(in_ready), 200'(1'b0));
            if (idx == stop_at - 1 && stop_at < 25) begin
                idx = stop_at;
            end else begin
                tick();
                if (res_ready) idx++;
            end
            cyc++;
        end
        res_ready = 1'b0;
        check_val("xfer_count", 200'(idx), 200'(stop_at));
        if (stop_at == 25) begin
            check_val("post_stream_valid", 200'(res_valid), 200'(1'b0));
            check_val("post_stream_busy", 200'(busy), 200'(1'b0));
            check_val("post_stream_in_ready", 200'(in_ready), 200'(1'b1));
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_cmd    = 2'b00;
        in_data   = 8'h00;
        in_opcode = 3'b000;
        res_ready = 1'b0;
        c_flat    = '0;
        alu_ovf   = 1'b0;
        repeat (3) tick();
        check_val("rst_A_flat", A_flat, 200'd0);
        check_val("rst_B_flat", B_flat, 200'd0);
        check_val("rst_opcode", 200'(opcode), 200'(3'b000));
        check_val("rst_res_valid", 200'(res_valid), 200'(1'b0));
        check_val("rst_busy", 200'(busy), 200'(1'b0));
        check_val("rst_loaded", 200'({a_loaded, b_loaded, err, res_ovf}), 200'(4'b0000));
        rst_n = 1'b1;
        tick();
        check_val("idle_in_ready", 200'(in_ready), 200'(1'b1));

        // A = 1..25, B = all 2, SUM -> 3..27
        for (int k = 0; k < 25; k++) send(CMD_LOAD_A, 8'(k + 1), 3'b000);
        for (int k = 0; k < 25; k++) send(CMD_LOAD_B, 8'd2, 3'b000);
        exp_flat = '0;
        for (int k = 0; k < 25; k++) exp_flat[k*8 +: 8] = 8'(k + 1);
        check_val("A_flat_ramp", A_flat, exp_flat);
        check_val("ab_loaded", 200'({a_loaded, b_loaded}), 200'(2'b11));
        for (int k = 0; k < 25; k++) exp_q[k] = 8'(k + 3);
        exec_op(3'b001, 8'd3);
        run_stream(1'b0, 25, 1'b0);

        // A = 127, B = 1 -> every element 0x80 with overflow, held after the stream
        send(CMD_CLEAR, 8'd0, 3'b000);
        check_val("clear_f", 200'(f), 200'd0);
        for (int k = 0; k < 25; k++) send(CMD_LOAD_A, 8'd127, 3'b000);
        for (int k = 0; k < 25; k++) send(CMD_LOAD_B, 8'd1, 3'b000);
        for (int k = 0; k < 25; k++) exp_q[k] = 8'h80;
        exec_op(3'b001, 8'd9);
        run_stream(1'b0, 25, 1'b1);
        repeat (3) tick();
        check_val("ovf_held_idle", 200'(res_ovf), 200'(1'b1));

        // Transpose of A = 1..25 twice; second run under backpressure
        send(CMD_CLEAR, 8'd0, 3'b000);
        for (int k = 0; k < 25; k++) send(CMD_LOAD_A, 8'(k + 1), 3'b000);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) exp_q[r*5 + c] = 8'(c*5 + r + 1);
        exec_op(3'b101, 8'd0);
        run_stream(1'b0, 25, 1'b0);
        exec_op(3'b101, 8'd0);
        run_stream(1'b1, 25, 1'b0);

        // Determinant: ALU returns zeros, streamed unchanged
        for (int k = 0; k < 25; k++) exp_q[k] = 8'h00;
        exec_op(3'b111, 8'd5);
        run_stream(1'b0, 25, 1'b0);

        // 26 writes wrap to element 0, then CLEAR and a rejected EXEC
        send(CMD_CLEAR, 8'd0, 3'b000);
        for (int k = 0; k < 26; k++) send(CMD_LOAD_A, 8'(k + 10), 3'b000);
        check_val("wrap_elem0", 200'(A_flat[7:0]), 200'(8'd35));
        check_val("wrap_elem1", 200'(A_flat[15:8]), 200'(8'd11));
        check_val("wrap_a_loaded", 200'(a_loaded), 200'(1'b1));
        check_val("wrap_b_loaded", 200'(b_loaded), 200'(1'b0));
        send(CMD_CLEAR, 8'd0, 3'b000);
        check_val("clear_A_flat", A_flat, 200'd0);
        check_val("clear_a_loaded", 200'(a_loaded), 200'(1'b0));
        send(CMD_EXEC, 8'd7, 3'b000);
        check_val("rej_err", 200'(err), 200'(1'b1));
        check_val("rej_busy", 200'(busy), 200'(1'b0));
        check_val("rej_f", 200'(f), 200'd0);
        tick();
        check_val("rej_err_pulse", 200'(err), 200'(1'b0));
        check_val("rej_busy2", 200'(busy), 200'(1'b0));

        // Asynchronous reset at stream element 10
        for (int k = 0; k < 25; k++) send(CMD_LOAD_A, 8'd1, 3'b000);
        for (int k = 0; k < 25; k++) exp_q[k] = 8'd1;
        exec_op(3'b001, 8'd4);
        run_stream(1'b0, 11, 1'b0);
        check_val("pre_rst_data", 200'(res_data), 200'(8'd1));
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_res_valid", 200'(res_valid), 200'(1'b0));
        check_val("rst_mid_opcode", 200'(opcode), 200'(3'b000));
        check_val("rst_mid_busy", 200'(busy), 200'(1'b0));
        #2;
        rst_n = 1'b1;
        tick();
        check_val("post_rst_in_ready", 200'(in_ready), 200'(1'b1));
        check_val("post_rst_A_flat", A_flat, 200'd0);
        check_val("post_rst_a_loaded", 200'(a_loaded), 200'(1'b0));
        check_val("post_rst_res_valid", 200'(res_valid), 200'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
